mem_delayed_model: RTL and testbench

Single-port, word-organised memory model that completes each read or write a fixed number of clock cycles after acceptance, using a busy/ack handshake. It stands in for main memory behind the core's load/store path, so the controller sees realistic multi-cycle latency. Addresses are byte addresses; storage is by 32-bit word.

---
 rtl/mem_delayed_model.sv | 116 +++++++++++
 tb/tb_mem_delayed_model.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_delayed_model.sv
// Word-organised single-port memory model with a fixed access latency.
// Each accepted read or write keeps busy high for mem_simulated_delay cycles,
// then completes with a one-cycle ack. Requests seen while busy are dropped.
module mem_delayed_model #(
  parameter int unsigned addr_width          = 32,
  parameter int unsigned data_width          = 32,
  parameter int unsigned mem_simulated_delay = 5,
  parameter int unsigned mem_words           = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wr_data,
  output logic [data_width-1:0] rd_data,
  output logic                  busy,
  output logic                  ack
);

  localparam int unsigned IDX_W = $clog2(mem_words);
  localparam int unsigned CNT_W = $clog2(mem_simulated_delay + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(mem_simulated_delay);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_accept;
  logic                  w_complete;
  logic                  r_is_wr;
  logic [IDX_W-1:0]      r_idx;
  logic [data_width-1:0] r_wdata;
  logic [data_width-1:0] r_rd_data;
  logic                  r_busy;
  logic                  r_ack;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_unused_addr;

  logic [data_width-1:0] r_mem [mem_words];

  // Byte offset and bits above the word index are deliberately ignored.
  assign w_idx         = addr[2 +: IDX_W];
  assign w_unused_addr = ^{addr[1:0], addr[addr_width-1:IDX_W+2]};

  assign rd_data = r_rd_data;
  assign busy    = r_busy;
  assign ack     = r_ack;

  // Next-state logic: accept in IDLE, count down in BUSY, complete on the last count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_LAST;
        if (r_cnt == CNT_LAST) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_wr   <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_BUSY);
      r_ack   <= w_complete;
      if (w_accept) begin
        // Write wins when both requests arrive together.
        r_is_wr <= wr_req;
        r_idx   <= w_idx;
        r_wdata <= wr_data;
      end
      if (w_complete && !r_is_wr) begin
        r_rd_data <= r_mem[r_idx];
      end
    end
  end

  // Storage commit; not reset, and an aborted access never reaches completion.
  always_ff @(posedge clk) begin
    if (w_complete && r_is_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_delayed_model.sv
// Directed bench for mem_delayed_model with hand-computed expectations.
module tb_mem_delayed_model;

  localparam int unsigned D = 5;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;
  logic        ack;

  int n_vec  = 0;
  int n_miss = 0;

  mem_delayed_model #(
    .addr_width(32),
    .data_width(32),
    .mem_simulated_delay(D),
    .mem_words(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_req(rd_req),
    .wr_req(wr_req),
    .addr(addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .busy(busy),
    .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request, then walks the busy window and stops in the ack cycle.
  // A non-negative pulse index drives a stray write (0x99 to 0x10) in that busy cycle.
  task automatic access(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input int pulse, input string tag);
    wr_req  = w;
    rd_req  = r;
    addr    = a;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    addr    = 'x;
    wr_data = 'x;
    for (int i = 0; i < int'(D); i++) begin
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      check({tag, " ack-low"}, {31'b0, ack}, 32'd0);
      wr_req = (i == pulse);
      if (i == pulse) begin
        addr    = 32'h10;
        wr_data = 32'h99;
      end
      tick();
    end
    check({tag, " done-busy"}, {31'b0, busy}, 32'd0);
    check({tag, " done-ack"}, {31'b0, ack}, 32'd1);
  endtask

  logic [31:0] rd_addr [6];
  logic [31:0] rd_exp  [6];

  initial begin
    rst     = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    addr    = '0;
    wr_data = '0;

    // Reset and idle
    tick();
    tick();
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst ack", {31'b0, ack}, 32'd0);
    check("rst rd_data", rd_data, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle busy", {31'b0, busy}, 32'd0);
      check("idle ack", {31'b0, ack}, 32'd0);
      check("idle rd_data", rd_data, 32'h0);
    end

    // Write latency with X address/data after acceptance
    access(1'b1, 1'b0, 32'h8, 32'hab, -1, "wr8");
    tick();
    check("wr8 ack-drop", {31'b0, ack}, 32'd0);
    check("wr8 idle-busy", {31'b0, busy}, 32'd0);

    access(1'b1, 1'b0, 32'h10, 32'hcd, -1, "wr10");
    access(1'b1, 1'b0, 32'h14, 32'h11, -1, "wr14");
    access(1'b1, 1'b0, 32'h18, 32'h22, -1, "wr18");
    check("writes keep rd_data", rd_data, 32'h0);

    // Back-to-back reads with rd_req held high; next address given in the ack cycle
    rd_addr[0] = 32'h10; rd_exp[0] = 32'hcd;
    rd_addr[1] = 32'h08; rd_exp[1] = 32'hab;
    rd_addr[2] = 32'h14; rd_exp[2] = 32'h11;
    rd_addr[3] = 32'h18; rd_exp[3] = 32'h22;
    rd_addr[4] = 32'h10; rd_exp[4] = 32'hcd;
    rd_addr[5] = 32'h08; rd_exp[5] = 32'hab;
    rd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      addr = rd_addr[k];
      tick();
      addr = 'x;
      for (int i = 0; i < int'(D); i++) begin
        check("b2b busy", {31'b0, busy}, 32'd1);
        check("b2b ack-low", {31'b0, ack}, 32'd0);
        tick();
      end
      check("b2b ack", {31'b0, ack}, 32'd1);
      check("b2b busy-low", {31'b0, busy}, 32'd0);
      check("b2b rd_data", rd_data, rd_exp[k]);
    end
    rd_req = 1'b0;
    tick();
    check("b2b end busy", {31'b0, busy}, 32'd0);
    check("b2b end ack", {31'b0, ack}, 32'd0);
    check("b2b hold rd_data", rd_data, 32'hab);

    // Byte-offset aliasing
    access(1'b1, 1'b0, 32'h8, 32'hab, -1, "al wr8");
    access(1'b1, 1'b0, 32'hb, 32'hcd, -1, "al wr11");
    access(1'b0, 1'b1, 32'h8, 32'h0, -1, "al rd8");
    check("alias 8/11", rd_data, 32'hcd);
    access(1'b1, 1'b0, 32'h8, 32'hab, -1, "al wr8b");
    access(1'b1, 1'b0, 32'hc, 32'hcd, -1, "al wr12");
    access(1'b0, 1'b1, 32'h8, 32'h0, -1, "al rd8b");
    check("alias rd8", rd_data, 32'hab);
    access(1'b0, 1'b1, 32'hc, 32'h0, -1, "al rd12");
    check("alias rd12", rd_data, 32'hcd);

    // Upper address bits wrap: 0x1000 + 0x14 maps onto word 5
    access(1'b0, 1'b1, 32'h1014, 32'h0, -1, "wrap rd");
    check("wrap rd_data", rd_data, 32'h11);

    // Stray write pulse while busy is ignored
    access(1'b0, 1'b1, 32'h10, 32'h0, 2, "pulse rd");
    check("pulse rd_data", rd_data, 32'hcd);
    tick();
    check("pulse no-accept", {31'b0, busy}, 32'd0);
    access(1'b0, 1'b1, 32'h10, 32'h0, -1, "pulse reread");
    check("pulse mem kept", rd_data, 32'hcd);

    // Simultaneous read and write: write wins, rd_data untouched
    access(1'b1, 1'b1, 32'h18, 32'h77, -1, "both");
    check("both rd_data kept", rd_data, 32'hcd);
    access(1'b0, 1'b1, 32'h18, 32'h0, -1, "both rd");
    check("both wrote", rd_data, 32'h77);

    // Reset in the 3rd busy cycle of a write aborts it
    access(1'b1, 1'b0, 32'h20, 32'h33, -1, "pre wr20");
    wr_req  = 1'b1;
    addr    = 32'h20;
    wr_data = 32'hee;
    tick();
    wr_req  = 1'b0;
    addr    = 'x;
    wr_data = 'x;
    tick();
    tick();
    check("abort pre busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort ack", {31'b0, ack}, 32'd0);
    check("abort rd_data", rd_data, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("post-rst idle", {31'b0, busy}, 32'd0);
    access(1'b0, 1'b1, 32'h20, 32'h0, -1, "abort rd20");
    check("abort mem kept", rd_data, 32'h33);
    tick();
    check("final ack", {31'b0, ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
